// File: rtl/scalar_branch_resolver.sv
// Resolves conditional branches against the scalar ALU condition flags.
// Stalls a branch while flag-writing compares are in flight; a writeback in the acceptance cycle is bypassed.
module scalar_branch_resolver #(
    parameter int DATA_W   = 36,
    parameter int MAX_PEND = 3,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmp_issue,
    output logic              cmp_ready,
    input  logic              flag_we,
    input  logic              nz,
    input  logic              ez,
    input  logic              lz,
    input  logic              gz,
    input  logic              le,
    input  logic              ge,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [DATA_W-1:0] br_pc,
    input  logic [DATA_W-1:0] br_off,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [DATA_W-1:0] res_target,
    output logic              flag_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [CNT_W-1:0]    pend_cnt_reg;
    logic [CNT_W-1:0]    pend_cnt_next;
    logic [5:0]          flag_reg;
    logic [5:0]          flag_in;
    logic [5:0]          eff_flags;
    logic [7:0]          cond_hit;
    logic                issue_ok;
    logic                dec_ok;
    logic                flags_clear;
    logic                br_accept;
    logic                taken_now;
    logic [DATA_W-1:0]   target_now;
    logic                res_taken_reg;
    logic [DATA_W-1:0]   res_target_reg;
    logic                flag_err_reg;

    assign flag_in   = {nz, ez, lz, gz, le, ge};
    assign eff_flags = flag_we ? flag_in : flag_reg;

    assign cmp_ready = (pend_cnt_reg < CNT_W'(MAX_PEND));
    assign issue_ok  = cmp_issue & cmp_ready;
    assign dec_ok    = flag_we & (pend_cnt_reg != '0);

    always_comb begin
        pend_cnt_next = pend_cnt_reg;
        if (issue_ok && !dec_ok) begin
            pend_cnt_next = pend_cnt_reg + CNT_W'(1);
        end else if (dec_ok && !issue_ok) begin
            pend_cnt_next = pend_cnt_reg - CNT_W'(1);
        end
    end

    // A compare issued alongside the branch is younger-in-flight data the branch must wait for.
    assign flags_clear = !cmp_issue &&
                         ((pend_cnt_reg == '0) ||
                          ((pend_cnt_reg == CNT_W'(1)) && flag_we));

    assign br_ready  = flags_clear && ((state_reg == ST_IDLE) || res_ready);
    assign br_accept = br_valid & br_ready;

    // Condition codes 001..110 select nz..ge in register order; 000 always, 111 never.
    assign cond_hit[0] = 1'b1;
    assign cond_hit[7] = 1'b0;
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_cond
            assign cond_hit[gi+1] = eff_flags[5-gi];
        end
    endgenerate

    assign taken_now  = cond_hit[br_cond];
    assign target_now = br_pc + DATA_W'(1) + (taken_now ? br_off : '0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (br_accept) state_next = ST_RESP;
            ST_RESP: if (res_ready && !br_accept) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            pend_cnt_reg   <= '0;
            flag_reg       <= '0;
            res_taken_reg  <= 1'b0;
            res_target_reg <= '0;
            flag_err_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pend_cnt_reg <= pend_cnt_next;
            if (flag_we) begin
                flag_reg <= flag_in;
            end
            if (flag_we && (pend_cnt_reg == '0)) begin
                flag_err_reg <= 1'b1;
            end
            if (br_accept) begin
                res_taken_reg  <= taken_now;
                res_target_reg <= target_now;
            end
        end
    end

    assign res_valid  = (state_reg == ST_RESP);
    assign res_taken  = res_taken_reg;
    assign res_target = res_target_reg;
    assign flag_err   = flag_err_reg;

endmodule
